psum_collector: RTL and testbench
=================================

// Module: psum_collector
// PURPOSE
//  Receive end of the systolic array's south psum port. Captures out_s words per
//  column whenever that column's valid bit is high. Columns arrive skewed in time.
//  Buffers each column in its own FIFO and presents full output rows to the
//  downstream SRAM writer. A row is presented only once every column holds a word.
//  Output is first-word-fall-through with a rd_en pop handshake.
// PARAMETERS
//  col      8   number of array columns / FIFO lanes
//  psum_bw  16  width of one psum word
//  depth    16  entries per column FIFO (power of 2, >=2)
// PORTS
//  clk       in   1            clock; all state updates on posedge
//  reset     in   1            synchronous, active-high
//  in        in   psum_bw*col  psum row from array; column c at [psum_bw*(c+1)-1:psum_bw*c]
//  wr        in   col          per-column write strobe (array valid); bit c writes column c
//  rd        in   1            pop one full row (honoured only when o_valid=1)
//  out       out  psum_bw*col  head row, same column packing as in
//  o_valid   out  1            every column FIFO is non-empty
//  o_full    out  1            at least one column FIFO holds depth entries
//  o_empty   out  1            every column FIFO is empty
//  o_ovf     out  1            sticky: a write was dropped on a full column
// BEHAVIOUR
//  - Reset: all rd/wr pointers and counts go to 0. o_ovf goes to 0.
//    Outputs after reset: o_valid=0, o_full=0, o_empty=1, out=0. FIFO memory is not reset.
//  - Per column c: wr_ptr_c and rd_ptr_c are log2(depth) bits wide; count_c is log2(depth)+1 bits.
//  - Pointers wrap modulo depth with no special case.
//  - pop = rd & o_valid. The pop is applied to all columns in the same cycle. rd with o_valid=0 is ignored.
//  - Column c accepts a write when wr[c] & (count_c<depth | pop).
//  - Accepted write: mem_c[wr_ptr_c] <= in slice c, then wr_ptr_c+1.
//  - Simultaneous write and pop on a column: count_c is unchanged. The write is accepted even if that
//    column was full, because the freed slot is reused the same cycle.
//  - Rejected write (wr[c], count_c==depth, no pop): data is dropped and o_ovf <= 1.
//    o_ovf stays 1 until reset.
//  - Flags are combinational from the registered counts:
//    o_valid=&(count_c!=0), o_full=|(count_c==depth), o_empty=&(count_c==0).
//  - out slice c = mem_c[rd_ptr_c] when o_valid=1, else 0. Zero latency (FWFT).
//  - A word written in cycle N is visible in out / counted in o_valid from cycle N+1.
//  - Column skew: a row completes when its last column is written. Earlier columns may
//    already be holding later rows. Rows pop in arrival order per column.
//  - Reset asserted mid-operation: contents are discarded and all state returns to reset values
//    on that edge. wr and rd are ignored while reset=1.
//  - in is sampled only for columns whose wr bit is set. Other slices are don't-care.
// TESTING
//  1 Reset: assert reset 2 cycles -> o_empty=1, o_valid=0, o_full=0, o_ovf=0, out=0.
//  2 Aligned write: wr=8'hFF, column c value = 16'h0100+c, for 1 cycle -> next cycle o_valid=1,
//    out matches; rd=1 -> next cycle o_empty=1.
//  3 Skewed: column c written at cycle t+c with value c, wr one-hot shifting.
//    -> o_valid stays 0 until cycle t+8, then 1. out = {7,...,0}.
//  4 Fill: 16 aligned rows with values 0..15, no rd -> o_full=1.
//    17th write -> o_ovf=1, and draining yields 0..15 exactly.
//  5 Full plus same-cycle rd and write of row 16 -> o_ovf stays 0, count stays 16.
//    Drained order is 1..16.
//  6 Mid-stream reset: 5 rows queued, reset 1 cycle -> o_empty=1, o_ovf=0.
//    Next written row is the first popped.

Source files
------------

// File: rtl/psum_collector.sv
// Receive side of the systolic array's south psum port: one FIFO per column,
// presenting a full output row (FWFT) only once every column holds a word.
module psum_collector #(
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int depth   = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [psum_bw*col-1:0] in,
    input  logic [col-1:0]         wr,
    input  logic                   rd,
    output logic [psum_bw*col-1:0] out,
    output logic                   o_valid,
    output logic                   o_full,
    output logic                   o_empty,
    output logic                   o_ovf
);

    localparam int aw = $clog2(depth);
    localparam logic [aw:0] full_cnt = (aw+1)'(depth);

    logic [psum_bw-1:0] mem    [col][depth];
    logic [aw-1:0]      wr_ptr [col];
    logic [aw-1:0]      rd_ptr [col];
    logic [aw:0]        count  [col];

    logic [col-1:0] nonempty;
    logic [col-1:0] at_depth;
    logic [col-1:0] accept;
    logic           pop;

    always_comb begin
        nonempty = '0;
        at_depth = '0;
        for (int c = 0; c < col; c++) begin
            nonempty[c] = (count[c] != '0);
            at_depth[c] = (count[c] == full_cnt);
        end
        o_valid = &nonempty;
        o_full  = |at_depth;
        o_empty = ~|nonempty;
        pop     = rd & o_valid;
        // A pop frees a slot this same cycle, so a full column may still accept.
        accept  = wr & (~at_depth | {col{pop}});
    end

    always_comb begin
        out = '0;
        if (o_valid) begin
            for (int c = 0; c < col; c++) begin
                out[psum_bw*c +: psum_bw] = mem[c][rd_ptr[c]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int c = 0; c < col; c++) begin
                if (accept[c]) begin
                    mem[c][wr_ptr[c]] <= in[psum_bw*c +: psum_bw];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < col; c++) begin
                wr_ptr[c] <= '0;
                rd_ptr[c] <= '0;
                count[c]  <= '0;
            end
            o_ovf <= 1'b0;
        end else begin
            for (int c = 0; c < col; c++) begin
                if (accept[c]) begin
                    wr_ptr[c] <= wr_ptr[c] + 1'b1;
                end
                if (pop) begin
                    rd_ptr[c] <= rd_ptr[c] + 1'b1;
                end
                case ({accept[c], pop})
                    2'b10:   count[c] <= count[c] + 1'b1;
                    2'b01:   count[c] <= count[c] - 1'b1;
                    default: count[c] <= count[c];
                endcase
                if (wr[c] && at_depth[c] && !pop) begin
                    o_ovf <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_psum_collector.sv
// Scoreboard bench for psum_collector: expected rows are queued at issue time
// and a monitor compares them against out on every popped row.
module tb_psum_collector;

    localparam int col     = 8;
    localparam int psum_bw = 16;
    localparam int depth   = 16;
    localparam int W       = psum_bw * col;

    logic           clk = 1'b0;
    logic           reset;
    logic [W-1:0]   in;
    logic [col-1:0] wr;
    logic           rd;
    logic [W-1:0]   out;
    logic           o_valid, o_full, o_empty, o_ovf;

    int n_tests = 0;
    int n_fail  = 0;
    logic [W-1:0] exp_q[$];

    psum_collector #(.col(col), .psum_bw(psum_bw), .depth(depth)) dut (
        .clk(clk), .reset(reset), .in(in), .wr(wr), .rd(rd), .out(out),
        .o_valid(o_valid), .o_full(o_full), .o_empty(o_empty), .o_ovf(o_ovf)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] mk_row(int base, int step);
        logic [W-1:0] r;
        r = '0;
        for (int c = 0; c < col; c++) r[psum_bw*c +: psum_bw] = 16'(base + step * c);
        return r;
    endfunction

    task automatic check(string name, logic [W-1:0] act, logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(int n);
        reset = 1'b1;
        repeat (n) tick();
        reset = 1'b0;
        wr    = '0;
        rd    = 1'b0;
        exp_q.delete();
    endtask

    task automatic write_row(logic [W-1:0] row, bit expect_kept);
        in = row;
        wr = '1;
        if (expect_kept) exp_q.push_back(row);
        tick();
        wr = '0;
    endtask

    task automatic drain(int n);
        rd = 1'b1;
        repeat (n) tick();
        rd = 1'b0;
    endtask

    // Monitor: every handshake that will pop at the next edge is checked here.
    always @(negedge clk) begin
        if (!reset && rd && o_valid) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_pop: got %h expected no row", out);
            end else begin
                check("pop_row", out, exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        in    = '0;
        wr    = '0;
        rd    = 1'b0;

        // 1: reset state
        do_reset(2);
        check("rst_empty", W'(o_empty), W'(1));
        check("rst_valid", W'(o_valid), W'(0));
        check("rst_full",  W'(o_full),  W'(0));
        check("rst_ovf",   W'(o_ovf),   W'(0));
        check("rst_out",   out,         '0);

        // 2: aligned write then pop
        write_row(mk_row(16'h0100, 1), 1'b1);
        check("aligned_valid", W'(o_valid), W'(1));
        check("aligned_out",   out, {16'h0107, 16'h0106, 16'h0105, 16'h0104,
                                     16'h0103, 16'h0102, 16'h0101, 16'h0100});
        drain(1);
        check("aligned_empty", W'(o_empty), W'(1));

        // 3: skewed columns, one-hot write strobe walking across
        exp_q.push_back(mk_row(0, 1));
        in = mk_row(0, 1);
        for (int c = 0; c < col; c++) begin
            wr    = '0;
            wr[c] = 1'b1;
            tick();
            if (c < col - 1) begin
                check("skew_valid_lo", W'(o_valid), W'(0));
                check("skew_out_zero", out, '0);
            end
        end
        wr = '0;
        check("skew_valid_hi", W'(o_valid), W'(1));
        check("skew_empty_lo", W'(o_empty), W'(0));
        drain(1);
        check("skew_empty", W'(o_empty), W'(1));

        // 4: fill to depth, overflow, drain
        for (int v = 0; v < depth; v++) write_row(mk_row(v, 16'h0100), 1'b1);
        check("fill_full", W'(o_full), W'(1));
        check("fill_ovf0", W'(o_ovf),  W'(0));
        write_row(mk_row(16'h0077, 0), 1'b0);
        check("fill_ovf1", W'(o_ovf), W'(1));
        drain(depth);
        check("fill_drained_empty", W'(o_empty), W'(1));
        check("fill_ovf_sticky",    W'(o_ovf),   W'(1));

        // 5: full with same-cycle pop and write
        do_reset(1);
        for (int v = 0; v < depth; v++) write_row(mk_row(v, 16'h0100), 1'b1);
        in = mk_row(16, 16'h0100);
        wr = '1;
        rd = 1'b1;
        exp_q.push_back(mk_row(16, 16'h0100));
        tick();
        wr = '0;
        rd = 1'b0;
        check("pw_ovf",  W'(o_ovf),  W'(0));
        check("pw_full", W'(o_full), W'(1));
        drain(depth);
        check("pw_empty", W'(o_empty), W'(1));

        // 6: reset mid-stream (strobes held during reset must be ignored)
        for (int v = 0; v < 5; v++) write_row(mk_row(16'h0020 + v, 1), 1'b1);
        in = mk_row(16'h0abc, 1);
        wr = '1;
        rd = 1'b1;
        do_reset(1);
        check("mid_empty", W'(o_empty), W'(1));
        check("mid_valid", W'(o_valid), W'(0));
        check("mid_ovf",   W'(o_ovf),   W'(0));
        write_row(mk_row(16'h0055, 2), 1'b1);
        check("mid_out", out, mk_row(16'h0055, 2));
        drain(1);
        check("mid_final_empty", W'(o_empty), W'(1));

        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_leftover: got %0d rows expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
